// File: rtl/binary_to_gray_code_converter.sv
// ----------------------------------------------------------------------------
// binary_to_gray_code_converter
//
// This module converts between binary and Gray code. The result is registered,
// so the latency is one cycle and one conversion can be accepted every cycle.
// Its typical use is between counters or pointers and clock-domain-crossing
// logic, for example to encode FIFO pointers.
//
// Optional feature (macro GRAY_STEP_CHECK_EN):
//   When the macro is defined, the module adds a step_err output. step_err
//   flags a binary->Gray result that differs from the previous binary->Gray
//   result in more than one bit. When the macro is undefined, the port and
//   all of its logic are absent.
//
// Parameters:
//   WIDTH      data width in bits, 2..32
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   qualifies data_in and mode this cycle
//   mode       0 = binary->Gray, 1 = Gray->binary
//   data_in    operand (binary or Gray per mode)
//   out_valid  data_out holds the result of an accepted input
//   data_out   registered conversion result
//   step_err   (GRAY_STEP_CHECK_EN only) multi-bit Gray step detected
// ----------------------------------------------------------------------------
module binary_to_gray_code_converter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             mode,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    logic [WIDTH-1:0] conv;

    // Binary->Gray is a single XOR with the operand shifted right by one.
    // Gray->binary is a descending XOR prefix chain that starts at the MSB.
    always_comb begin
        // NOTE: conv receives a default before the branches, so no path leaves it unassigned and no latch is inferred.
        conv = data_in ^ (data_in >> 1);
        if (mode) begin
            conv[WIDTH-1] = data_in[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                conv[i] = conv[i+1] ^ data_in[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // data_out holds its last value while in_valid is low; there is no bubble clear.
            if (in_valid) begin
                data_out <= conv;
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    // prev_gray is the most recent valid binary->Gray result. ref_ok stays
    // low until the first such result arrives, so that the first result after
    // reset is never flagged.
    logic [WIDTH-1:0] prev_gray;
    logic             ref_ok;
    logic [WIDTH-1:0] diff;
    logic             multi_bit;

    // diff & (diff - 1) clears the lowest set bit. If anything remains
    // afterwards, more than one bit changed. A diff of zero, which is a
    // repeated value, is therefore not an error.
    assign diff      = conv ^ prev_gray;
    assign multi_bit = (diff & (diff - WIDTH'(1))) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray <= '0;
            ref_ok    <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            // step_err is a one-cycle flag aligned with out_valid. Idle cycles
            // and Gray->binary transfers drive it low.
            step_err <= 1'b0;
            if (in_valid && !mode) begin
                step_err  <= ref_ok && multi_bit;
                prev_gray <= conv;
                ref_ok    <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_binary_to_gray_code_converter.sv
// ----------------------------------------------------------------------------
// tb_binary_to_gray_code_converter
//
// Directed testbench for binary_to_gray_code_converter with WIDTH=4. All
// expected values are hand-computed constants. When GRAY_STEP_CHECK_EN is
// defined, the bench also checks the step_err output.
// ----------------------------------------------------------------------------
module tb_binary_to_gray_code_converter;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
`ifdef GRAY_STEP_CHECK_EN
    logic             step_err;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    // Hand-computed Gray codes for binary 0..15.
    logic [3:0] gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                  4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    binary_to_gray_code_converter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .mode     (mode),
        .data_in  (data_in),
        .out_valid(out_valid),
        .data_out (data_out)
`ifdef GRAY_STEP_CHECK_EN
        ,
        .step_err (step_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one transfer, wait for the next rising edge, then settle for 1
    // time unit so that outputs are sampled away from the edge.
    task automatic step(input logic v, input logic m, input logic [3:0] d);
        in_valid = v;
        mode     = m;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. Reset while a valid input is presented.
        rst      = 1'b1;
        in_valid = 1'b1;
        mode     = 1'b0;
        data_in  = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'hF);
        check("post_rst_out_valid", 32'(out_valid), 32'h0);
        check("post_rst_data_out", 32'(data_out), 32'h0);

        // 2. Back-to-back sweep of binary->Gray.
        for (int b = 0; b < 16; b++) begin
            step(1'b1, 1'b0, 4'(b));
            check($sformatf("sweep_gray_%0d", b), 32'(data_out), 32'(gray_tbl[b]));
            check($sformatf("sweep_valid_%0d", b), 32'(out_valid), 32'h1);
        end

        // 3. Gray->binary spot vectors and a full round trip.
        step(1'b1, 1'b1, 4'b1000);
        check("g2b_1000", 32'(data_out), 32'hF);
        step(1'b1, 1'b1, 4'b0110);
        check("g2b_0110", 32'(data_out), 32'h4);
        for (int b = 0; b < 16; b++) begin
            step(1'b1, 1'b1, gray_tbl[b]);
            check($sformatf("roundtrip_%0d", b), 32'(data_out), 32'(b));
        end

        // 4. Mode alternating every cycle, followed by one idle cycle.
        step(1'b1, 1'b0, 4'h5);
        check("alt_b2g_5", 32'(data_out), 32'h7);
        step(1'b1, 1'b1, 4'h7);
        check("alt_g2b_7", 32'(data_out), 32'h5);
        step(1'b1, 1'b0, 4'h9);
        check("alt_b2g_9", 32'(data_out), 32'hD);
        check("alt_valid", 32'(out_valid), 32'h1);
        step(1'b0, 1'b0, 4'h3);
        check("idle_out_valid", 32'(out_valid), 32'h0);
        check("idle_hold", 32'(data_out), 32'hD);

        // 5. Reset in the middle of a sweep. The outputs must clear without a clock edge.
        for (int b = 0; b < 6; b++) step(1'b1, 1'b0, 4'(b));
        check("pre_mid_rst", 32'(data_out), 32'h7);
        in_valid = 1'b1;
        data_in  = 4'h6;
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_data_out", 32'(data_out), 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 4'h7);
        check("resume_7", 32'(data_out), 32'h4);
        check("resume_valid", 32'(out_valid), 32'h1);

`ifdef GRAY_STEP_CHECK_EN
        // 6. Step checker. Reset first so that the reference starts fresh.
        rst = 1'b1;
        #1;
        check("se_rst", 32'(step_err), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 1'b0, 4'd3);
        check("se_first", 32'(step_err), 32'h0);
        step(1'b1, 1'b0, 4'd4);
        check("se_2_to_6", 32'(step_err), 32'h0);
        step(1'b1, 1'b0, 4'd7);
        check("se_6_to_4", 32'(step_err), 32'h0);
        step(1'b1, 1'b0, 4'd0);
        check("se_4_to_0", 32'(step_err), 32'h0);
        step(1'b1, 1'b0, 4'd10);
        check("se_0_to_F", 32'(step_err), 32'h1);
        check("se_0_to_F_data", 32'(data_out), 32'hF);
        step(1'b0, 1'b0, 4'd0);
        check("se_one_cycle", 32'(step_err), 32'h0);
        step(1'b1, 1'b0, 4'd10);
        check("se_repeat", 32'(step_err), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
